mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_map_pkg.sv | 37 +++
 rtl/dp_ram.sv | 34 +++
 rtl/sync2.sv | 27 ++
 rtl/mem_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the CPU-side memory controller:
// FSM state encoding, address-map constants, data width and the decoder.
package mem_map_pkg;

    localparam int          DATA_W       = 16;
    localparam int          ADDR_W       = 16;
    localparam logic [15:0] RAM_BASE     = 16'h0000;
    localparam logic [15:0] RAM_LIMIT    = 16'h03FF;
    localparam logic [15:0] MAP_LED_ADDR = 16'hFFFE;
    localparam logic [15:0] MAP_SW_ADDR  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        AK_RAM  = 2'd0,
        AK_LED  = 2'd1,
        AK_SW   = 2'd2,
        AK_NONE = 2'd3
    } kind_t;

    // Full 16-bit decode: the offset form keeps the RAM window exact, so
    // nothing outside RAM_BASE..RAM_LIMIT aliases onto the RAM.
    function automatic kind_t decode(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] led_addr,
                                     input logic [ADDR_W-1:0] sw_addr);
        if ((addr - RAM_BASE) <= (RAM_LIMIT - RAM_BASE)) return AK_RAM;
        if (addr == led_addr)                            return AK_LED;
        if (addr == sw_addr)                             return AK_SW;
        return AK_NONE;
    endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple true dual-port RAM with synchronous read (q valid one cycle after
// the address edge). Read-during-write on the same port returns old data.
module dp_ram #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_we_a,
    input  logic [AWIDTH-1:0] i_addr_a,
    input  logic [DWIDTH-1:0] i_data_a,
    output logic [DWIDTH-1:0] o_q_a,
    input  logic              i_we_b,
    input  logic [AWIDTH-1:0] i_addr_b,
    input  logic [DWIDTH-1:0] i_data_b,
    output logic [DWIDTH-1:0] o_q_b
);

    logic [DWIDTH-1:0] r_mem [2**AWIDTH];
    logic [DWIDTH-1:0] r_q_a;
    logic [DWIDTH-1:0] r_q_b;

    // Both ports write and read in one process; simultaneous writes to the
    // same word resolve in favour of port B.
    always_ff @(posedge i_clk) begin
        if (i_we_a) r_mem[i_addr_a] <= i_data_a;
        if (i_we_b) r_mem[i_addr_b] <= i_data_b;
        r_q_a <= r_mem[i_addr_a];
        r_q_b <= r_mem[i_addr_b];
    end

    assign o_q_a = r_q_a;
    assign o_q_b = r_q_b;

endmodule

// File: rtl/sync2.sv
// Two-flop synchronizer for quasi-static asynchronous inputs (board switches).
module sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/mem_ctrl.sv
// CPU memory controller: decodes a 16-bit word address onto RAM port A,
// an LED register and a synchronized switch input.
//
// Handshake: cpu_req is a level request sampled only in IDLE; the request
// fields are latched on that edge and may change afterwards. cpu_ready is a
// single-cycle completion pulse (cycle 2 for store/I/O/unmapped, cycle 3 for
// a RAM load, counted from the sampling edge); cpu_rdata is valid while
// cpu_ready is high and holds until the next load completes. A request
// still high in the cycle after cpu_ready is accepted as a new access.
module mem_ctrl
    import mem_map_pkg::*;
#(
    parameter int          RAM_AWIDTH = 10,
    parameter logic [15:0] LED_ADDR   = MAP_LED_ADDR,
    parameter logic [15:0] SW_ADDR    = MAP_SW_ADDR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_ready,
    output logic                  addr_fault,
    output logic                  mem_we,
    output logic [RAM_AWIDTH-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_data,
    input  logic [DATA_W-1:0]     mem_q,
    input  logic [DATA_W-1:0]     io_sw,
    output logic [DATA_W-1:0]     io_led
);

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_fault;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_led;

    kind_t               w_acc_kind;
    kind_t               w_kind;
    logic [DATA_W-1:0]   w_sw_sync;

    // Decode of the incoming address (for the early write strobe) and of the
    // latched address (for everything that happens after acceptance).
    assign w_acc_kind = decode(cpu_addr, LED_ADDR, SW_ADDR);
    assign w_kind     = decode(r_addr, LED_ADDR, SW_ADDR);

    sync2 #(
        .WIDTH (DATA_W)
    ) u_sw_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (io_sw),
        .o_q     (w_sw_sync)
    );

    // Access sequencer: IDLE latches the request, ISSUE drives the RAM or
    // completes I/O, WAIT captures RAM read data, RESP pulses cpu_ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_ready  <= 1'b0;
            r_fault  <= 1'b0;
            r_mem_we <= 1'b0;
            r_led    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_we     <= cpu_we;
                        r_addr   <= cpu_addr;
                        r_wdata  <= cpu_wdata;
                        // Registered so the strobe covers exactly the ISSUE cycle.
                        r_mem_we <= cpu_we && (w_acc_kind == AK_RAM);
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_mem_we <= 1'b0;
                    if ((w_kind == AK_RAM) && !r_we) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_RESP;
                        r_ready <= 1'b1;
                        r_fault <= (w_kind == AK_NONE);
                        if (r_we && (w_kind == AK_LED)) r_led <= r_wdata;
                        if (!r_we) begin
                            case (w_kind)
                                AK_LED:  r_rdata <= r_led;
                                AK_SW:   r_rdata <= w_sw_sync;
                                AK_NONE: r_rdata <= '0;
                                default: r_rdata <= r_rdata;
                            endcase
                        end
                    end
                end
                ST_WAIT: begin
                    r_rdata <= mem_q;
                    r_ready <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_ready <= 1'b0;
                    r_fault <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rdata  = r_rdata;
    assign cpu_ready  = r_ready;
    assign addr_fault = r_fault;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr[RAM_AWIDTH-1:0];
    assign mem_data   = r_wdata;
    assign io_led     = r_led;

endmodule
